// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg
// Shared types and constants for the cartridge RAM arbiter.
//   arb_state_t  : arbiter FSM states (IDLE, BUSY, DONE)
//   RAM_DATA_W   : byte-wide RAM data path
//   STARVE_CNT_W : width of the requester-0 starvation counter
//   id_w(n)      : width of a requester index for n requesters (minimum 1)
package ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    localparam int RAM_DATA_W   = 8;
    localparam int STARVE_CNT_W = 4;

    function automatic int id_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ram_arb_rr_pick.sv
// ram_arb_rr_pick
// Combinational round-robin picker over the background requesters 1..NUM_REQ-1.
// The search starts at i_ptr+1 and wraps from NUM_REQ-1 back to 1, so the
// requester granted last is considered last.
// Ports:
//   i_req   : request levels of requesters NUM_REQ-1..1
//   i_ptr   : index of the last background requester granted
//   o_valid : at least one background requester is pending
//   o_idx   : index of the selected requester (valid with o_valid)
module ram_arb_rr_pick
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ = 3,
    localparam int ID_W    = id_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:1] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic               o_valid,
    output logic [ID_W-1:0]    o_idx
);

    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        // Candidate k is ((ptr + k) mod (N-1)) + 1, i.e. ptr+1, ptr+2, ... wrapping within 1..N-1.
        for (int k = 0; k < NUM_REQ - 1; k++) begin
            if (!o_valid && i_req[((int'(i_ptr) + k) % (NUM_REQ - 1)) + 1]) begin
                o_valid = 1'b1;
                o_idx   = ID_W'(((int'(i_ptr) + k) % (NUM_REQ - 1)) + 1);
            end
        end
    end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter
// Shares one byte-wide cartridge RAM port between several requesters.
// Requester 0 (mega-ROM path) has fixed priority, requesters 1..NUM_REQ-1
// rotate round-robin, and a starvation counter limits how many consecutive
// requester-0 grants can pass while a background requester waits.
// Ports:
//   CLK, RESET        : clock, asynchronous active-high reset
//   REQ, WE           : per-requester request level and write enable
//   ADDR, WDATA       : flattened per-requester address / write data
//   ACK               : one-cycle one-hot completion pulse
//   RDATA             : read data, meaningful while an ACK bit is high
//   RAM_REQ..RAM_WDATA: latched request towards the RAM controller
//   RAM_RDATA, RAM_ACK: RAM controller response
//   GRANT_ID          : index of the current/last owner
module ram_arbiter
    import ram_arb_pkg::*;
#(
    parameter  int NUM_REQ      = 3,
    parameter  int ADDR_W       = 21,
    parameter  int STARVE_LIMIT = 4,
    localparam int ID_W         = id_w(NUM_REQ)
) (
    input  logic                          CLK,
    input  logic                          RESET,
    input  logic [NUM_REQ-1:0]            REQ,
    input  logic [NUM_REQ-1:0]            WE,
    input  logic [NUM_REQ*ADDR_W-1:0]     ADDR,
    input  logic [NUM_REQ*RAM_DATA_W-1:0] WDATA,
    output logic [NUM_REQ-1:0]            ACK,
    output logic [RAM_DATA_W-1:0]         RDATA,
    output logic                          RAM_REQ,
    output logic                          RAM_WE,
    output logic [ADDR_W-1:0]             RAM_ADDR,
    output logic [RAM_DATA_W-1:0]         RAM_WDATA,
    input  logic [RAM_DATA_W-1:0]         RAM_RDATA,
    input  logic                          RAM_ACK,
    output logic [ID_W-1:0]               GRANT_ID
);

    arb_state_t              r_state;
    logic [ID_W-1:0]         r_grant_id;
    logic [ID_W-1:0]         r_rr_ptr;
    logic [STARVE_CNT_W-1:0] r_starve_cnt;
    logic                    r_ram_req;
    logic                    r_ram_we;
    logic [ADDR_W-1:0]       r_ram_addr;
    logic [RAM_DATA_W-1:0]   r_ram_wdata;
    logic [RAM_DATA_W-1:0]   r_rdata;
    logic [NUM_REQ-1:0]      r_ack;

    logic                    w_others;
    logic                    w_pick_valid;
    logic [ID_W-1:0]         w_pick_idx;
    logic                    w_grant0;
    logic                    w_any;
    logic [ID_W-1:0]         w_winner;

    ram_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .i_req   (REQ[NUM_REQ-1:1]),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_pick_valid),
        .o_idx   (w_pick_idx)
    );

    assign w_others = |REQ[NUM_REQ-1:1];
    // Requester 0 loses only when it has hit the limit AND someone else is waiting.
    assign w_grant0 = REQ[0] && ((int'(r_starve_cnt) < STARVE_LIMIT) || !w_others);
    assign w_any    = REQ[0] || w_pick_valid;
    assign w_winner = w_grant0 ? '0 : w_pick_idx;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state      <= IDLE;
            r_grant_id   <= '0;
            r_rr_ptr     <= ID_W'(NUM_REQ - 1);
            r_starve_cnt <= '0;
            r_ram_req    <= 1'b0;
            r_ram_we     <= 1'b0;
            r_ram_addr   <= '0;
            r_ram_wdata  <= '0;
            r_rdata      <= '0;
            r_ack        <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_ack <= '0;
                    if (w_any) begin
                        r_ram_req   <= 1'b1;
                        r_ram_we    <= WE[w_winner];
                        r_ram_addr  <= ADDR[int'(w_winner)*ADDR_W +: ADDR_W];
                        r_ram_wdata <= WDATA[int'(w_winner)*RAM_DATA_W +: RAM_DATA_W];
                        r_grant_id  <= w_winner;
                        r_state     <= BUSY;
                        if (w_grant0) begin
                            // Count only grants that actually made someone else wait.
                            if (w_others) begin
                                if (r_starve_cnt != '1)
                                    r_starve_cnt <= r_starve_cnt + STARVE_CNT_W'(1);
                            end else begin
                                r_starve_cnt <= '0;
                            end
                        end else begin
                            r_starve_cnt <= '0;
                            r_rr_ptr     <= w_pick_idx;
                        end
                    end
                end
                BUSY: begin
                    if (RAM_ACK) begin
                        if (!r_ram_we)
                            r_rdata <= RAM_RDATA;
                        r_ram_req <= 1'b0;
                        r_ack     <= NUM_REQ'(1) << r_grant_id;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    r_ack   <= '0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign ACK       = r_ack;
    assign RDATA     = r_rdata;
    assign RAM_REQ   = r_ram_req;
    assign RAM_WE    = r_ram_we;
    assign RAM_ADDR  = r_ram_addr;
    assign RAM_WDATA = r_ram_wdata;
    assign GRANT_ID  = r_grant_id;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter
// Self-checking bench for ram_arbiter (NUM_REQ=3, ADDR_W=21, STARVE_LIMIT=4).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_arbiter;

    logic        CLK;
    logic        RESET;
    logic [2:0]  REQ;
    logic [2:0]  WE;
    logic [62:0] ADDR;
    logic [23:0] WDATA;
    logic [2:0]  ACK;
    logic [7:0]  RDATA;
    logic        RAM_REQ;
    logic        RAM_WE;
    logic [20:0] RAM_ADDR;
    logic [7:0]  RAM_WDATA;
    logic [7:0]  RAM_RDATA;
    logic        RAM_ACK;
    logic [1:0]  GRANT_ID;

    int checks = 0;
    int errors = 0;

    ram_arbiter #(
        .NUM_REQ      (3),
        .ADDR_W       (21),
        .STARVE_LIMIT (4)
    ) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .REQ       (REQ),
        .WE        (WE),
        .ADDR      (ADDR),
        .WDATA     (WDATA),
        .ACK       (ACK),
        .RDATA     (RDATA),
        .RAM_REQ   (RAM_REQ),
        .RAM_WE    (RAM_WE),
        .RAM_ADDR  (RAM_ADDR),
        .RAM_WDATA (RAM_WDATA),
        .RAM_RDATA (RAM_RDATA),
        .RAM_ACK   (RAM_ACK),
        .GRANT_ID  (GRANT_ID)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

    typedef struct {
        logic [2:0]  req;
        logic [2:0]  we;
        logic [62:0] addr;
        logic [23:0] wdata;
        logic [7:0]  ram_rd;
        int          delay;
        logic [1:0]  exp_gid;
        logic [20:0] exp_addr;
        logic        exp_we;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_rdata;
        logic [2:0]  exp_ack;
    } vec_t;

    vec_t vec [7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply_reset();
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
    endtask

    // One complete transaction; entered and left on a falling edge with the arbiter in IDLE.
    task automatic do_txn(input vec_t v, input string tag);
        int   n;
        logic stable_ok;
        REQ       = v.req;
        WE        = v.we;
        ADDR      = v.addr;
        WDATA     = v.wdata;
        RAM_RDATA = v.ram_rd;
        n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while (!RAM_REQ && n < 5);
        check({tag, ".ram_req_latency"}, 32'(n), 32'd1);
        if (!RAM_REQ) begin
            REQ = '0;
            return;
        end
        check({tag, ".grant_id"}, 32'(GRANT_ID), 32'(v.exp_gid));
        check({tag, ".ram_addr"}, 32'(RAM_ADDR), 32'(v.exp_addr));
        check({tag, ".ram_we"}, 32'(RAM_WE), 32'(v.exp_we));
        check({tag, ".ram_wdata"}, 32'(RAM_WDATA), 32'(v.exp_wdata));
        stable_ok = 1'b1;
        for (int d = 0; d < v.delay; d++) begin
            @(negedge CLK);
            if (RAM_REQ !== 1'b1 || RAM_ADDR !== v.exp_addr || RAM_WE !== v.exp_we ||
                RAM_WDATA !== v.exp_wdata || GRANT_ID !== v.exp_gid || ACK !== 3'b000)
                stable_ok = 1'b0;
        end
        if (v.delay > 0)
            check({tag, ".held_stable"}, 32'(stable_ok), 32'd1);
        RAM_ACK = 1'b1;
        @(negedge CLK);
        RAM_ACK = 1'b0;
        check({tag, ".ack"}, 32'(ACK), 32'(v.exp_ack));
        check({tag, ".rdata"}, 32'(RDATA), 32'(v.exp_rdata));
        check({tag, ".ram_req_dropped"}, 32'(RAM_REQ), 32'd0);
        REQ = '0;
        @(negedge CLK);
        check({tag, ".ack_one_cycle"}, 32'(ACK), 32'd0);
    endtask

    // Hold REQ constant and answer every RAM_REQ immediately; exp_ids packs 2 bits per grant.
    task automatic run_grants(input logic [2:0] req, input int n, input logic [19:0] exp_ids, input string tag);
        int w;
        REQ       = req;
        WE        = '0;
        RAM_RDATA = 8'h00;
        for (int g = 0; g < n; g++) begin
            @(negedge CLK);
            w = 0;
            while (!RAM_REQ && w < 4) begin
                @(negedge CLK);
                w++;
            end
            check({tag, ".ram_req_seen"}, 32'(RAM_REQ), 32'd1);
            if (!RAM_REQ) begin
                REQ = '0;
                return;
            end
            check($sformatf("%s.grant%0d", tag, g), 32'(GRANT_ID), 32'(exp_ids[2*g +: 2]));
            RAM_ACK = 1'b1;
            @(negedge CLK);
            RAM_ACK = 1'b0;
            check($sformatf("%s.ack%0d", tag, g), 32'(ACK), 32'(3'b001 << exp_ids[2*g +: 2]));
        end
        REQ = '0;
        @(negedge CLK);
    endtask

    initial begin
        RESET     = 1'b1;
        REQ       = '0;
        WE        = '0;
        ADDR      = '0;
        WDATA     = '0;
        RAM_RDATA = '0;
        RAM_ACK   = 1'b0;

        // req, we, addr{a2,a1,a0}, wdata{w2,w1,w0}, ram_rd, delay, gid, addr, we, wdata, rdata, ack
        vec[0] = '{3'b010, 3'b000, {21'h0, 21'h01234, 21'h0}, 24'h0, 8'h5A, 0,
                   2'd1, 21'h01234, 1'b0, 8'h00, 8'h5A, 3'b010};
        vec[1] = '{3'b100, 3'b100, {21'h1FFFFF, 21'h0, 21'h0}, {8'hA5, 8'h00, 8'h00}, 8'h99, 10,
                   2'd2, 21'h1FFFFF, 1'b1, 8'hA5, 8'h5A, 3'b100};
        vec[2] = '{3'b001, 3'b000, {21'h0, 21'h0, 21'h00010}, 24'h0, 8'h11, 1,
                   2'd0, 21'h00010, 1'b0, 8'h00, 8'h11, 3'b001};
        vec[3] = '{3'b111, 3'b000, {21'h00ACC, 21'h100BB, 21'h000AA}, {8'h03, 8'h02, 8'h01}, 8'h22, 0,
                   2'd0, 21'h000AA, 1'b0, 8'h01, 8'h22, 3'b001};
        vec[4] = '{3'b110, 3'b000, {21'h00ACC, 21'h100BB, 21'h000AA}, {8'h03, 8'h02, 8'h01}, 8'h33, 2,
                   2'd1, 21'h100BB, 1'b0, 8'h02, 8'h33, 3'b010};
        vec[5] = '{3'b110, 3'b000, {21'h00ACC, 21'h100BB, 21'h000AA}, {8'h03, 8'h02, 8'h01}, 8'h44, 0,
                   2'd2, 21'h00ACC, 1'b0, 8'h03, 8'h44, 3'b100};
        vec[6] = '{3'b011, 3'b001, {21'h00ACC, 21'h100BB, 21'h000AA}, {8'h03, 8'h02, 8'h3C}, 8'h55, 0,
                   2'd0, 21'h000AA, 1'b1, 8'h3C, 8'h44, 3'b001};

        repeat (2) @(negedge CLK);
        check("reset.ram_req", 32'(RAM_REQ), 32'd0);
        check("reset.ack", 32'(ACK), 32'd0);
        check("reset.rdata", 32'(RDATA), 32'd0);
        check("reset.grant_id", 32'(GRANT_ID), 32'd0);
        check("reset.ram_addr", 32'(RAM_ADDR), 32'd0);
        check("reset.ram_we", 32'(RAM_WE), 32'd0);
        check("reset.ram_wdata", 32'(RAM_WDATA), 32'd0);
        RESET = 1'b0;
        @(negedge CLK);
        check("idle.no_req", 32'(RAM_REQ), 32'd0);

        for (int i = 0; i < 7; i++)
            do_txn(vec[i], $sformatf("vec%0d", i));

        // Priority with starvation cap: four requester-0 grants, then requester 1.
        apply_reset();
        run_grants(3'b011, 10, 20'h40100, "starve");

        // Round-robin among background requesters: 1,2,1,2.
        apply_reset();
        run_grants(3'b110, 4, 20'h00099, "rr");

        // Reset in the middle of BUSY, late RAM_ACK afterwards.
        REQ  = 3'b010;
        WE   = '0;
        ADDR = {21'h0, 21'h0ABCD, 21'h0};
        @(negedge CLK);
        check("rst_mid.ram_req_up", 32'(RAM_REQ), 32'd1);
        repeat (2) @(negedge CLK);
        RESET = 1'b1;
        #1;
        check("rst_mid.ram_req_async", 32'(RAM_REQ), 32'd0);
        check("rst_mid.ack_async", 32'(ACK), 32'd0);
        check("rst_mid.ram_addr", 32'(RAM_ADDR), 32'd0);
        REQ = '0;
        @(negedge CLK);
        RESET = 1'b0;
        @(negedge CLK);
        RAM_ACK   = 1'b1;
        RAM_RDATA = 8'hEE;
        @(negedge CLK);
        RAM_ACK = 1'b0;
        check("rst_mid.late_ack_ignored", 32'(ACK), 32'd0);
        check("rst_mid.ram_req_idle", 32'(RAM_REQ), 32'd0);
        check("rst_mid.rdata_reset", 32'(RDATA), 32'd0);
        @(negedge CLK);
        check("rst_mid.no_ack_later", 32'(ACK), 32'd0);
        begin
            vec_t v;
            v = '{3'b010, 3'b000, {21'h0, 21'h0ABCD, 21'h0}, 24'h0, 8'h66, 1,
                  2'd1, 21'h0ABCD, 1'b0, 8'h00, 8'h66, 3'b010};
            do_txn(v, "rst_mid.next");
        end

        // Back-to-back: requester 0 keeps REQ high through ACK.
        REQ  = 3'b001;
        WE   = '0;
        ADDR = {21'h0, 21'h0, 21'h00123};
        RAM_RDATA = 8'h0F;
        @(negedge CLK);
        check("b2b.first_req", 32'(RAM_REQ), 32'd1);
        RAM_ACK = 1'b1;
        @(negedge CLK);
        RAM_ACK = 1'b0;
        check("b2b.first_ack", 32'(ACK), 32'd1);
        @(negedge CLK);
        check("b2b.gap_ack", 32'(ACK), 32'd0);
        check("b2b.gap_ram_req", 32'(RAM_REQ), 32'd0);
        @(negedge CLK);
        check("b2b.second_req", 32'(RAM_REQ), 32'd1);
        RAM_RDATA = 8'hF0;
        RAM_ACK   = 1'b1;
        @(negedge CLK);
        RAM_ACK = 1'b0;
        check("b2b.second_ack", 32'(ACK), 32'd1);
        check("b2b.second_rdata", 32'(RDATA), 32'hF0);
        REQ = '0;
        @(negedge CLK);
        check("b2b.end_ack", 32'(ACK), 32'd0);
        @(negedge CLK);
        check("b2b.end_idle", 32'(RAM_REQ), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
